// File: rtl/spi_word_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_cfg_pkg
// Purpose  : Shared types and constants for the SPI word master slice.
//            Holds the transfer FSM state encoding, the default word
//            width and the lower bound on the SCLK divider.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package spi_cfg_pkg;

  localparam int DATA_W_DEF  = 16;
  // Smallest divider that still gives a distinct SCLK high and low phase.
  localparam int CLK_DIV_MIN = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_word_master_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_word_master_if
// Purpose  : Bundle of the sequencer handshake and SPI pin signals.
// Ports    : master modport (serializer side):
//              in  spi_start, spi_data, spi_miso
//              out spi_busy, data_end, rx_data, spi_sclk, spi_mosi, spi_cs
//            slave modport (sequencer/pad side): the same, directions swapped
// Revision : 1.0 - initial release
// ============================================================================
interface spi_word_master_if
  import spi_cfg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              spi_start;
  logic [DATA_W-1:0] spi_data;
  logic              spi_busy;
  logic              data_end;
  logic [DATA_W-1:0] rx_data;
  logic              spi_miso;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_cs;

  modport master (
    input  spi_start, spi_data, spi_miso,
    output spi_busy, data_end, rx_data, spi_sclk, spi_mosi, spi_cs
  );

  modport slave (
    output spi_start, spi_data, spi_miso,
    input  spi_busy, data_end, rx_data, spi_sclk, spi_mosi, spi_cs
  );

endinterface
`default_nettype wire

// File: rtl/spi_word_master_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_tick_gen
// Purpose  : Free-running divider producing a one-cycle tick every DIV
//            enabled clk_i cycles. clear_i restarts the count from zero.
// Ports    : clk_i   in  system clock
//            rst     in  asynchronous active-high reset
//            clear_i in  synchronous counter clear (wins over en_i)
//            en_i    in  count enable
//            tick_o  out tick pulse (only while en_i is high)
// Revision : 1.0 - initial release
// ============================================================================
module spi_tick_gen
  import spi_cfg_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  // Dividers below the minimum are clamped so the counter never degenerates.
  localparam int            DIV_EFF = (DIV < CLK_DIV_MIN) ? CLK_DIV_MIN : DIV;
  localparam int            CW      = $clog2(DIV_EFF);
  localparam logic [CW-1:0] LAST    = CW'(DIV_EFF - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == LAST);

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_word_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_word_master
// Purpose  : SPI mode 0 word serializer. Accepts one DATA_W-bit word per
//            request, shifts it out on SCLK/MOSI under CS, assembles MISO
//            into rx_data and pulses data_end when CS returns high.
//            Build option: SPI_LSB_FIRST_EN selects LSB-first order in both
//            directions; MSB-first when undefined.
// Ports    : clk_i in  system clock
//            rst   in  asynchronous active-high reset
//            bus   master modport of spi_word_master_if (handshake + pins)
// Revision : 1.0 - initial release
// ============================================================================
module spi_word_master
  import spi_cfg_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 1
) (
  input  logic                clk_i,
  input  logic                rst,
  spi_word_master_if.master   bus
);

  localparam int             BCW       = $clog2(DATA_W) + 1;
  localparam int             GCW       = $clog2(CS_GAP + 1) + 1;
  localparam logic [BCW-1:0] BITS_LAST = BCW'(DATA_W);
  localparam logic [GCW-1:0] GAP_LAST  = GCW'(CS_GAP);

  spi_state_e        state_q, state_d;
  logic              armed_q, armed_d;
  logic              sclk_q, sclk_d;
  logic              cs_q, cs_d;
  logic              busy_q, busy_d;
  logic              de_q, de_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [BCW-1:0]    bit_q, bit_d;
  logic [GCW-1:0]    gap_q, gap_d;

  logic              tick;
  logic              accept;
  logic              mosi;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;

  assign accept = (state_q == IDLE) && bus.spi_start && armed_q;

  // MOSI is always the outgoing end of the transmit register, so it keeps
  // the last bit once shifting stops and is 0 out of reset.
`ifdef SPI_LSB_FIRST_EN
  assign mosi     = tx_q[0];
  assign tx_shift = {1'b0, tx_q[DATA_W-1:1]};
  assign rx_shift = {bus.spi_miso, rx_sh_q[DATA_W-1:1]};
`else
  assign mosi     = tx_q[DATA_W-1];
  assign tx_shift = {tx_q[DATA_W-2:0], 1'b0};
  assign rx_shift = {rx_sh_q[DATA_W-2:0], bus.spi_miso};
`endif

  spi_tick_gen #(
    .DIV (CLK_DIV)
  ) u_tick_gen (
    .clk_i   (clk_i),
    .rst     (rst),
    .clear_i (accept),
    .en_i    (state_q != IDLE),
    .tick_o  (tick)
  );

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      armed_q <= 1'b1;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      de_q    <= 1'b0;
      tx_q    <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      de_q    <= de_d;
      tx_q    <= tx_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    busy_d  = busy_q;
    de_d    = 1'b0;
    tx_d    = tx_q;
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    gap_d   = gap_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          armed_d = 1'b0;
          tx_d    = bus.spi_data;
          bit_d   = '0;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          state_d = SETUP;
        end else if (!bus.spi_start) begin
          // A request only re-arms after the sequencer has dropped it here.
          armed_d = 1'b1;
        end
      end

      SETUP: begin
        if (tick) state_d = SHIFT;
      end

      SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            rx_sh_d = rx_shift;
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 1'b1;
            // The final falling edge leaves MOSI on the last bit.
            if (bit_d == BITS_LAST) state_d = HOLD;
            else                    tx_d    = tx_shift;
          end
        end
      end

      HOLD: begin
        if (tick) begin
          cs_d    = 1'b1;
          de_d    = 1'b1;
          rx_d    = rx_sh_q;
          gap_d   = '0;
          state_d = GAP;
        end
      end

      GAP: begin
        if (tick) begin
          gap_d = gap_q + 1'b1;
          if (gap_d == GAP_LAST) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.spi_sclk = sclk_q;
  assign bus.spi_mosi = mosi;
  assign bus.spi_cs   = cs_q;
  assign bus.spi_busy = busy_q;
  assign bus.data_end = de_q;
  assign bus.rx_data  = rx_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_word_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_word_master
// Purpose  : Self-checking bench for spi_word_master. dut0 uses the default
//            CS gap with a scoreboard monitor; dut1 uses CS_GAP=3.
//            Honours SPI_LSB_FIRST_EN for bit-order dependent expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_word_master;

  typedef struct packed {
    logic [15:0] tx;
    logic [15:0] rx;
  } exp_t;

  logic clk;
  logic rst;

  int   n_tests = 0;
  int   n_fail  = 0;

  spi_word_master_if #(.DATA_W(16)) bus0 ();
  spi_word_master_if #(.DATA_W(16)) bus1 ();

  spi_word_master #(.DATA_W(16), .CLK_DIV(4), .CS_GAP(1)) u_dut0 (
    .clk_i (clk),
    .rst   (rst),
    .bus   (bus0)
  );

  spi_word_master #(.DATA_W(16), .CLK_DIV(4), .CS_GAP(3)) u_dut1 (
    .clk_i (clk),
    .rst   (rst),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Position of the k-th transmitted/received bit in the word.
  function automatic int bit_pos(input int k);
`ifdef SPI_LSB_FIRST_EN
    return k;
`else
    return 15 - k;
`endif
  endfunction

  // ---------------- MISO drive for dut0: loopback or fixed pattern --------
  logic        loop0 = 1'b1;
  logic [15:0] pat0  = 16'h0000;
  int          fall_cnt0 = 0;
  logic        pat_bit0;

  always @(negedge bus0.spi_cs)   fall_cnt0 = 0;
  always @(negedge bus0.spi_sclk) fall_cnt0++;

  always_comb begin
    pat_bit0 = 1'b0;
    if (fall_cnt0 < 16) pat_bit0 = pat0[bit_pos(fall_cnt0)];
  end

  assign bus0.spi_miso = loop0 ? bus0.spi_mosi : pat_bit0;
  assign bus1.spi_miso = bus1.spi_mosi;

  // ---------------- MOSI capture for dut0 ----------------------------------
  logic [15:0] cap0 = '0;
  int          rise_cnt0 = 0;
  logic        first_bit0 = 1'b0;

  always @(posedge bus0.spi_sclk) begin
    if (rise_cnt0 == 0) first_bit0 = bus0.spi_mosi;
`ifdef SPI_LSB_FIRST_EN
    cap0 = {bus0.spi_mosi, cap0[15:1]};
`else
    cap0 = {cap0[14:0], bus0.spi_mosi};
`endif
    rise_cnt0++;
  end

  // ---------------- scoreboard monitor for dut0 ----------------------------
  exp_t sb_q[$];
  int   cyc0 = 0;
  int   acc_cyc0 = 0;
  int   de_cnt0 = 0;
  logic busy_prev0 = 1'b0;
  logic mosi_hi0 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    cyc0++;
    if (rst) begin
      busy_prev0 = 1'b0;
    end else begin
      if (bus0.spi_busy && !busy_prev0) begin
        acc_cyc0  = cyc0;
        cap0      = '0;
        rise_cnt0 = 0;
        mosi_hi0  = 1'b0;
      end
      if (bus0.spi_busy && bus0.spi_mosi) mosi_hi0 = 1'b1;
      busy_prev0 = bus0.spi_busy;
      if (bus0.data_end) begin
        de_cnt0++;
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_data_end: got data_end=1, expected none (rx=%0h)", bus0.rx_data);
        end else begin
          e = sb_q.pop_front();
          chk("rx_data",    {16'h0, bus0.rx_data}, {16'h0, e.rx});
          chk("mosi_word",  {16'h0, cap0}, {16'h0, e.tx});
          chk("sclk_rises", rise_cnt0, 16);
          chk("latency",    cyc0 - acc_cyc0, 136);
          chk("cs_at_end",  {31'h0, bus0.spi_cs}, 1);
        end
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic wait_idle0();
    int n = 0;
    while (bus0.spi_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus0.spi_busy) chk("busy_fall_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic wait_de0(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus0.data_end && n < 400);
    if (!bus0.data_end) chk(nm, 0, 1);
  endtask

  task automatic run_xfer0(input logic [15:0] tx, input logic [15:0] rx_exp);
    int n = 0;
    sb_q.push_back('{tx: tx, rx: rx_exp});
    bus0.spi_data  = tx;
    bus0.spi_start = 1'b1;
    do begin
      @(negedge clk);
      n++;
      // Changing the word mid-transfer must not affect what is shifted out.
      if (n == 20) bus0.spi_data = ~tx;
    end while (!bus0.data_end && n < 400);
    if (!bus0.data_end) chk("xfer_timeout", 0, 1);
    bus0.spi_start = 1'b0;
    wait_idle0();
  endtask

  // ---------------- main sequence ------------------------------------------
  initial begin
    int base;
    int n;

    rst            = 1'b1;
    bus0.spi_start = 1'b0;
    bus0.spi_data  = '0;
    bus1.spi_start = 1'b0;
    bus1.spi_data  = '0;
    repeat (3) @(negedge clk);

    chk("rst_sclk", {31'h0, bus0.spi_sclk},     0);
    chk("rst_mosi", {31'h0, bus0.spi_mosi},     0);
    chk("rst_cs",   {31'h0, bus0.spi_cs},       1);
    chk("rst_busy", {31'h0, bus0.spi_busy},     0);
    chk("rst_de",   {31'h0, bus0.data_end},     0);
    chk("rst_rx",   {16'h0, bus0.rx_data},      0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Loopback, 0001_0101_1111_1111.
    loop0 = 1'b1;
    run_xfer0(16'h15FF, 16'h15FF);

    // Start held high for 300 cycles: exactly one transfer.
    base = de_cnt0;
    sb_q.push_back('{tx: 16'h7F49, rx: 16'h7F49});
    bus0.spi_data  = 16'h7F49;
    bus0.spi_start = 1'b1;
    repeat (300) @(negedge clk);
    chk("held_start_one_xfer", de_cnt0 - base, 1);
    chk("held_start_idle",     {31'h0, bus0.spi_busy}, 0);
    // Drop for one cycle, then raise again: a second transfer.
    bus0.spi_start = 1'b0;
    @(negedge clk);
    sb_q.push_back('{tx: 16'h7F49, rx: 16'h7F49});
    bus0.spi_start = 1'b1;
    wait_de0("rearm_timeout");
    bus0.spi_start = 1'b0;
    wait_idle0();
    chk("rearm_second_xfer", de_cnt0 - base, 2);

    // Pattern on MISO while sending zeros.
    loop0 = 1'b0;
    pat0  = 16'hA5C3;
    run_xfer0(16'h0000, 16'hA5C3);
    chk("mosi_stays_zero", {31'h0, mosi_hi0}, 0);
    loop0 = 1'b1;

    // Reset about 60 cycles into a transfer, while SCLK is high.
    base = de_cnt0;
    bus0.spi_data  = 16'h1234;
    bus0.spi_start = 1'b1;
    n = 0;
    while (!bus0.spi_busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    repeat (57) @(negedge clk);
    chk("sclk_high_before_rst", {31'h0, bus0.spi_sclk}, 1);
    rst = 1'b1;
    #1;
    chk("midrst_cs",   {31'h0, bus0.spi_cs},   1);
    chk("midrst_sclk", {31'h0, bus0.spi_sclk}, 0);
    chk("midrst_busy", {31'h0, bus0.spi_busy}, 0);
    bus0.spi_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("midrst_no_data_end", de_cnt0 - base, 0);
    run_xfer0(16'hC33C, 16'hC33C);

    // Single set bit: order of the first transmitted bit.
    run_xfer0(16'h0001, 16'h0001);
`ifdef SPI_LSB_FIRST_EN
    chk("first_mosi_bit", {31'h0, first_bit0}, 1);
`else
    chk("first_mosi_bit", {31'h0, first_bit0}, 0);
`endif

    // dut1: CS_GAP=3, busy stays high 12 cycles after data_end.
    bus1.spi_data  = 16'h5A0F;
    bus1.spi_start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus1.data_end && n < 400);
    if (!bus1.data_end) chk("gap_de_timeout", 0, 1);
    chk("gap_rx_data", {16'h0, bus1.rx_data}, 32'h5A0F);
    bus1.spi_start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 4) bus1.spi_start = 1'b1;   // request arrives inside the gap
    end while (bus1.spi_busy && n < 50);
    chk("gap_busy_cycles", n, 12);
    repeat (20) @(negedge clk);
    chk("gap_request_deferred", {31'h0, bus1.spi_busy}, 0);
    bus1.spi_start = 1'b0;
    @(negedge clk);
    bus1.spi_start = 1'b1;
    n = 0;
    while (!bus1.spi_busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("gap_next_accept", {31'h0, bus1.spi_busy}, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus1.data_end && n < 400);
    if (!bus1.data_end) chk("gap_de2_timeout", 0, 1);
    chk("gap_rx_data2", {16'h0, bus1.rx_data}, 32'h5A0F);
    bus1.spi_start = 1'b0;

    repeat (30) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
